// File: rtl/fsb_cs_decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fsb_cs_decoder_pkg
//  Purpose  : Shared types and defaults for the FSB chip-select decoder:
//             overlay state encoding, nibble bitmaps, snoop windows.
//  Revision : 1.0  initial release
// ============================================================================
package fsb_cs_decoder_pkg;

  // Boot-overlay states; encoding 2'd3 is illegal and recovers to OVL_ON.
  typedef enum logic [1:0] {
    OVL_ON    = 2'd0,
    OVL_ARMED = 2'd1,
    OVL_OFF   = 2'd2
  } ovl_state_t;

  // Default top-nibble bitmaps (bit n <=> A[AW-1:AW-4] == n).
  localparam logic [15:0] C_NIB_IO_DEF   = 16'hFF20;
  localparam logic [15:0] C_NIB_ROM_DEF  = 16'h0010;
  localparam logic [15:0] C_NIB_IACK_DEF = 16'h8000;
  localparam logic [3:0]  C_ODCS_NIB_DEF = 4'h4;
  localparam logic [2:0]  C_OVL_PFX_DEF  = 3'b011;

  // Default sound-RAM snoop windows, compared against A[15:8].
  localparam logic [7:0]  C_SNP_LO0_DEF  = 8'hFE;
  localparam logic [7:0]  C_SNP_HI0_DEF  = 8'hFF;
  localparam logic [7:0]  C_SNP_LO1_DEF  = 8'hA2;
  localparam logic [7:0]  C_SNP_HI1_DEF  = 8'hA3;

  // Inclusive range test used by the snoop windows.
  function automatic logic in_window(input logic [7:0] a,
                                     input logic [7:0] lo,
                                     input logic [7:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fsb_berr_timer.sv
`default_nettype none
// ============================================================================
//  Module   : fsb_berr_timer
//  Purpose  : Tracks the active bus cycle and raises BERR after BERR_CYC
//             clocks of an active cycle to an unmapped address.
//  Revision : 1.0  initial release
// ============================================================================
module fsb_berr_timer #(
  parameter int BERR_CYC = 255
) (
  input  logic CLK,
  input  logic RES,
  input  logic ASActive,
  input  logic ASInactive,
  input  logic Unmapped,
  output logic BERR
);

  localparam int            CW    = $clog2(BERR_CYC + 1);
  localparam logic [CW-1:0] C_MAX = CW'(BERR_CYC);

  logic          r_active;
  logic [CW-1:0] r_cnt;
  logic          r_berr;
  logic          w_active_nxt;
  logic [CW-1:0] w_cnt_nxt;

  // Next-state: ASActive wins over ASInactive; counter saturates at C_MAX.
  always_comb begin
    w_active_nxt = r_active;
    if (ASActive)
      w_active_nxt = 1'b1;
    else if (ASInactive)
      w_active_nxt = 1'b0;

    w_cnt_nxt = r_cnt;
    if (ASActive)
      w_cnt_nxt = '0;
    else if (r_active && Unmapped && (r_cnt < C_MAX))
      w_cnt_nxt = r_cnt + 1'b1;
  end

  // BERR is gated by the next Active so it drops on the ASInactive edge.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_berr   <= 1'b0;
    end else begin
      r_active <= w_active_nxt;
      r_cnt    <= w_cnt_nxt;
      r_berr   <= w_active_nxt && (w_cnt_nxt == C_MAX);
    end
  end

  assign BERR = r_berr;

endmodule
`default_nettype wire

// File: rtl/fsb_cs_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : fsb_cs_decoder
//  Purpose  : FSB chip-select decoder with boot overlay, sound-RAM write
//             snoop windows and an optional bus-error timer.
//  Revision : 1.0  initial release
// ============================================================================
module fsb_cs_decoder
  import fsb_cs_decoder_pkg::*;
#(
  parameter int          AW       = 24,
  parameter logic [15:0] NIB_IO   = C_NIB_IO_DEF,
  parameter logic [15:0] NIB_ROM  = C_NIB_ROM_DEF,
  parameter logic [15:0] NIB_IACK = C_NIB_IACK_DEF,
  parameter logic [3:0]  ODCS_NIB = C_ODCS_NIB_DEF,
  parameter logic [2:0]  OVL_PFX  = C_OVL_PFX_DEF,
  parameter logic [7:0]  SNP_LO0  = C_SNP_LO0_DEF,
  parameter logic [7:0]  SNP_HI0  = C_SNP_HI0_DEF,
  parameter logic [7:0]  SNP_LO1  = C_SNP_LO1_DEF,
  parameter logic [7:0]  SNP_HI1  = C_SNP_HI1_DEF,
  parameter bit          BERR_EN  = 1'b1,
  parameter int          BERR_CYC = 255
) (
  input  logic          CLK,
  input  logic          RES,
  input  logic [AW-1:8] A,
  input  logic          nWE,
  input  logic          ASActive,
  input  logic          ASInactive,
  output logic          RAMCS,
  output logic          ROMCS,
  output logic          IOCS,
  output logic          IACS,
  output logic          SndRAMCSWR,
  output logic          Unmapped,
  output logic          Overlay,
  output logic          BERR
);

  ovl_state_t r_state;
  logic       r_overlay;

  logic [3:0] w_top;
  logic       w_ramcs;
  logic       w_romcs;
  logic       w_iacs;
  logic       w_vidwr;
  logic       w_iocs;
  logic       w_snoop;
  logic       w_unmapped;

  assign w_top = A[AW-1:AW-4];

  // Zero-latency selects; they overlap on purpose (video writes hit RAM and IOB).
  always_comb begin
    w_ramcs    = ((A[AW-1:AW-2] == 2'b00) && !r_overlay) ||
                 ((A[AW-1:AW-3] == OVL_PFX) && r_overlay);
    w_romcs    = NIB_ROM[w_top] || ((w_top == 4'h0) && r_overlay);
    w_iacs     = NIB_IACK[w_top];
    w_vidwr    = w_ramcs && (&A[AW-3:16]) && !nWE;
    w_iocs     = NIB_IO[w_top] || w_iacs || w_vidwr;
    w_snoop    = w_vidwr && (in_window(A[15:8], SNP_LO0, SNP_HI0) ||
                             in_window(A[15:8], SNP_LO1, SNP_HI1));
    w_unmapped = !(w_ramcs || w_romcs || w_iocs);
  end

  // Overlay FSM: ON until an ODCS access arms it, OFF after the arming cycle ends.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      r_state   <= OVL_ON;
      r_overlay <= 1'b1;
    end else begin
      case (r_state)
        OVL_ON: begin
          r_overlay <= 1'b1;
          if (ASActive && (w_top == ODCS_NIB))
            r_state <= OVL_ARMED;
        end
        OVL_ARMED: begin
          // A same-cycle ASInactive while ON closed the previous cycle, so
          // only an ASInactive seen here ends the arming cycle.
          if (ASInactive) begin
            r_state   <= OVL_OFF;
            r_overlay <= 1'b0;
          end
        end
        OVL_OFF: begin
          r_overlay <= 1'b0;
        end
        default: begin
          r_state   <= OVL_ON;
          r_overlay <= 1'b1;
        end
      endcase
    end
  end

  generate
    if (BERR_EN) begin : g_berr
      fsb_berr_timer #(
        .BERR_CYC (BERR_CYC)
      ) u_berr_timer (
        .CLK        (CLK),
        .RES        (RES),
        .ASActive   (ASActive),
        .ASInactive (ASInactive),
        .Unmapped   (w_unmapped),
        .BERR       (BERR)
      );
    end else begin : g_no_berr
      assign BERR = 1'b0;
    end
  endgenerate

  assign RAMCS      = w_ramcs;
  assign ROMCS      = w_romcs;
  assign IOCS       = w_iocs;
  assign IACS       = w_iacs;
  assign SndRAMCSWR = w_snoop;
  assign Unmapped   = w_unmapped;
  assign Overlay    = r_overlay;

endmodule
`default_nettype wire

// File: tb/tb_fsb_cs_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fsb_cs_decoder
//  Purpose  : Directed self-checking bench for fsb_cs_decoder (BERR_CYC=8).
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fsb_cs_decoder;

  logic         CLK = 1'b0;
  logic         RES = 1'b1;
  logic [23:8]  A = '0;
  logic         nWE = 1'b1;
  logic         ASActive = 1'b0;
  logic         ASInactive = 1'b0;
  logic         RAMCS, ROMCS, IOCS, IACS, SndRAMCSWR, Unmapped, Overlay, BERR;

  int n_cmp = 0;
  int n_err = 0;

  fsb_cs_decoder #(
    .AW       (24),
    .BERR_EN  (1'b1),
    .BERR_CYC (8)
  ) dut (
    .CLK        (CLK),
    .RES        (RES),
    .A          (A),
    .nWE        (nWE),
    .ASActive   (ASActive),
    .ASInactive (ASInactive),
    .RAMCS      (RAMCS),
    .ROMCS      (ROMCS),
    .IOCS       (IOCS),
    .IACS       (IACS),
    .SndRAMCSWR (SndRAMCSWR),
    .Unmapped   (Unmapped),
    .Overlay    (Overlay),
    .BERR       (BERR)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Inputs change just after a falling edge; next rising edge samples them.
  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic set_addr(input logic [23:0] addr);
    A = addr[23:8];
    #1;
  endtask

  task automatic pulse_act();
    ASActive = 1'b1; tick(); ASActive = 1'b0;
  endtask

  task automatic pulse_inact();
    ASInactive = 1'b1; tick(); ASInactive = 1'b0;
  endtask

  task automatic do_reset();
    RES = 1'b1; #2; RES = 1'b0; tick();
  endtask

  initial begin
    // ---- 1: reset state and overlay decode ----
    tick();
    check_eq("rst_overlay", Overlay, 1'b1);
    check_eq("rst_berr", BERR, 1'b0);
    RES = 1'b0;
    set_addr(24'h000000);
    check_eq("ovl_a0_romcs", ROMCS, 1'b1);
    check_eq("ovl_a0_ramcs", RAMCS, 1'b0);
    set_addr(24'h600000);
    check_eq("ovl_a6_ramcs", RAMCS, 1'b1);
    set_addr(24'h200000);
    check_eq("ovl_a2_unmapped", Unmapped, 1'b1);
    tick();

    // ---- 2: arm at ODCS, drop after the next ASInactive ----
    set_addr(24'h400000);
    pulse_act();
    check_eq("armed_overlay", Overlay, 1'b1);
    tick();
    check_eq("armed_hold", Overlay, 1'b1);
    pulse_inact();
    check_eq("off_overlay", Overlay, 1'b0);
    set_addr(24'h000000);
    check_eq("off_a0_ramcs", RAMCS, 1'b1);
    check_eq("off_a0_romcs", ROMCS, 1'b0);
    tick();

    // ---- 3: same-cycle ASActive(ODCS)+ASInactive only arms ----
    do_reset();
    set_addr(24'h400000);
    ASActive = 1'b1; ASInactive = 1'b1; tick(); ASActive = 1'b0; ASInactive = 1'b0;
    check_eq("same_cyc_overlay", Overlay, 1'b1);
    tick();
    check_eq("same_cyc_hold", Overlay, 1'b1);
    pulse_inact();
    check_eq("same_cyc_off", Overlay, 1'b0);

    // ---- 4: video writes and snoop windows (overlay off) ----
    nWE = 1'b0;
    set_addr(24'h3FFE00);
    check_eq("vid_fe_ramcs", RAMCS, 1'b1);
    check_eq("vid_fe_iocs", IOCS, 1'b1);
    check_eq("vid_fe_snd", SndRAMCSWR, 1'b1);
    set_addr(24'h3FFF00);
    check_eq("vid_ff_snd", SndRAMCSWR, 1'b1);
    set_addr(24'h3FA200);
    check_eq("vid_a2_snd", SndRAMCSWR, 1'b1);
    set_addr(24'h3FA300);
    check_eq("vid_a3_snd", SndRAMCSWR, 1'b1);
    set_addr(24'h3FA100);
    check_eq("vid_a1_snd", SndRAMCSWR, 1'b0);
    set_addr(24'h3FA400);
    check_eq("vid_a4_snd", SndRAMCSWR, 1'b0);
    set_addr(24'h3FFD00);
    check_eq("vid_fd_snd", SndRAMCSWR, 1'b0);
    check_eq("vid_fd_iocs", IOCS, 1'b1);
    set_addr(24'h3EFE00);
    check_eq("novid_iocs", IOCS, 1'b0);
    check_eq("novid_snd", SndRAMCSWR, 1'b0);
    nWE = 1'b1;
    set_addr(24'h3FFE00);
    check_eq("rd_fe_iocs", IOCS, 1'b0);
    check_eq("rd_fe_snd", SndRAMCSWR, 1'b0);
    check_eq("rd_fe_unmapped", Unmapped, 1'b0);
    set_addr(24'hF00000);
    check_eq("iack_iacs", IACS, 1'b1);
    check_eq("iack_iocs", IOCS, 1'b1);
    set_addr(24'hE00000);
    check_eq("io_e_iacs", IACS, 1'b0);
    check_eq("io_e_iocs", IOCS, 1'b1);
    set_addr(24'h500000);
    check_eq("io_5_iocs", IOCS, 1'b1);
    set_addr(24'h400000);
    check_eq("rom_4_romcs", ROMCS, 1'b1);
    set_addr(24'h600000);
    check_eq("off_a6_unmapped", Unmapped, 1'b1);
    tick();

    // ---- 5: bus-error timer on an unmapped cycle ----
    pulse_act();
    for (int i = 1; i <= 7; i++) begin
      check_eq("berr_early", BERR, 1'b0);
      tick();
    end
    check_eq("berr_pre8", BERR, 1'b0);
    tick();
    check_eq("berr_at8", BERR, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("berr_hold", BERR, 1'b1);
    end
    pulse_inact();
    check_eq("berr_clear", BERR, 1'b0);
    tick();
    check_eq("berr_stay_low", BERR, 1'b0);
    set_addr(24'hE00000);
    pulse_act();
    for (int i = 0; i < 100; i++) begin
      tick();
      check_eq("berr_mapped", BERR, 1'b0);
    end
    pulse_inact();

    // ---- 6: async reset mid-timeout ----
    set_addr(24'h600000);
    pulse_act();
    repeat (5) tick();
    RES = 1'b1; #1;
    check_eq("rst5_berr", BERR, 1'b0);
    check_eq("rst5_overlay", Overlay, 1'b1);
    #1; RES = 1'b0; tick();
    // Overlay is back on, so 0x200000 is unmapped again.
    set_addr(24'h200000);
    check_eq("rst5_unmapped", Unmapped, 1'b1);
    repeat (10) tick();
    check_eq("rst5_idle_berr", BERR, 1'b0);
    pulse_act();
    for (int i = 1; i <= 7; i++) tick();
    check_eq("restart_pre8", BERR, 1'b0);
    tick();
    check_eq("restart_at8", BERR, 1'b1);
    RES = 1'b1; #1;
    check_eq("rst_berr_async", BERR, 1'b0);
    check_eq("rst_ovl_async", Overlay, 1'b1);
    #1; RES = 1'b0; tick();
    pulse_act();
    for (int i = 1; i <= 7; i++) tick();
    check_eq("restart2_pre8", BERR, 1'b0);
    tick();
    check_eq("restart2_at8", BERR, 1'b1);
    pulse_inact();
    check_eq("restart2_clear", BERR, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
